// File: rtl/chimera_pmu_cluster_seq.sv
// chimera_pmu_cluster_seq
// Power sequencer for NumClusters independent cluster power domains. Each
// cluster runs its own FSM:
//   OFF -> WAKE_RST -> WAKE_ISO -> ON -> SLP_ISO -> SLP_CLK -> OFF
// This ordering keeps the cluster clock running while reset is held and
// releases isolation only after reset. On the way down, isolation is applied
// before the clock is gated and reset is asserted last.
//
// Ports (each vector has one bit per cluster):
//   clk_i              soc clock (single domain)
//   rst_i              synchronous active-high reset
//   target_on_i        level request: 1 = powered/running, 0 = off
//   iso_ack_clusters_i isolation acknowledge from the cluster domain
//   clear_timeout_i    single-cycle pulse, clears sticky timeout flag
//   rst_clusters_no    active-low cluster reset
//   iso_en_clusters_o  isolation enable
//   clk_gate_en_o      1 = cluster clock gated
//   on_o               1 while in ON
//   busy_o             1 while in a transitional state
//   timeout_o          sticky acknowledge-timeout flag
module chimera_pmu_cluster_seq #(
  parameter int NumClusters = 5,
  parameter int RstCycles   = 16,
  parameter int AckTimeout  = 256
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NumClusters-1:0] target_on_i,
  input  logic [NumClusters-1:0] iso_ack_clusters_i,
  input  logic [NumClusters-1:0] clear_timeout_i,
  output logic [NumClusters-1:0] rst_clusters_no,
  output logic [NumClusters-1:0] iso_en_clusters_o,
  output logic [NumClusters-1:0] clk_gate_en_o,
  output logic [NumClusters-1:0] on_o,
  output logic [NumClusters-1:0] busy_o,
  output logic [NumClusters-1:0] timeout_o
);

  localparam int WaitW = $clog2(AckTimeout + 1);
  localparam logic [7:0]       RstLoad  = 8'(RstCycles - 1);
  // The wait state is left on its AckTimeout-th cycle (count starts at 0 on entry).
  localparam logic [WaitW-1:0] WaitLast = WaitW'(AckTimeout - 1);
  localparam logic [WaitW-1:0] WaitMax  = WaitW'(AckTimeout);
  localparam logic [WaitW-1:0] WaitOne  = WaitW'(1);
  localparam logic [WaitW-1:0] WaitZero = WaitW'(0);

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_WAKE_RST = 3'd1,
    ST_WAKE_ISO = 3'd2,
    ST_ON       = 3'd3,
    ST_SLP_ISO  = 3'd4,
    ST_SLP_CLK  = 3'd5
  } state_e;

  // Output pattern per state: {rst_no, iso_en, clk_gate_en, on, busy}.
  localparam logic [4:0] OutOff = 5'b01100;

  function automatic logic [4:0] decode_outputs(input state_e st);
    logic [4:0] res;
    case (st)
      ST_OFF:      res = 5'b01100;
      ST_WAKE_RST: res = 5'b01001;
      ST_WAKE_ISO: res = 5'b10001;
      ST_ON:       res = 5'b10010;
      ST_SLP_ISO:  res = 5'b11001;
      ST_SLP_CLK:  res = 5'b11101;
      default:     res = 5'b01100;
    endcase
    return res;
  endfunction

  for (genvar g = 0; g < NumClusters; g++) begin : g_cluster
    state_e           state_r, state_next_s;
    logic [7:0]       rst_cnt_r, rst_cnt_next_s;
    logic [WaitW-1:0] wait_cnt_r, wait_cnt_next_s, wait_inc_s;
    logic             timeout_r, timeout_next_s, set_timeout_s;
    logic             wait_expired_s;
    logic [4:0]       out_r;

    // Next-state, counter and timeout-flag logic for one cluster.
    always_comb begin
      state_next_s    = state_r;
      rst_cnt_next_s  = rst_cnt_r;
      wait_cnt_next_s = wait_cnt_r;
      set_timeout_s   = 1'b0;
      wait_expired_s  = (wait_cnt_r >= WaitLast);
      // Saturating increment: the wait counter never wraps.
      if (wait_cnt_r != WaitMax) begin
        wait_inc_s = wait_cnt_r + WaitOne;
      end else begin
        wait_inc_s = wait_cnt_r;
      end
      case (state_r)
        ST_OFF: begin
          if (target_on_i[g]) begin
            state_next_s   = ST_WAKE_RST;
            rst_cnt_next_s = RstLoad;
          end else begin
            state_next_s = ST_OFF;
          end
        end
        ST_WAKE_RST: begin
          if (rst_cnt_r == 8'd0) begin
            state_next_s    = ST_WAKE_ISO;
            wait_cnt_next_s = WaitZero;
          end else begin
            rst_cnt_next_s = rst_cnt_r - 8'd1;
          end
        end
        ST_WAKE_ISO: begin
          // Isolation release is acknowledged by ack going low.
          if (!iso_ack_clusters_i[g]) begin
            state_next_s = ST_ON;
          end else if (wait_expired_s) begin
            state_next_s  = ST_ON;
            set_timeout_s = 1'b1;
          end else begin
            wait_cnt_next_s = wait_inc_s;
          end
        end
        ST_ON: begin
          if (!target_on_i[g]) begin
            state_next_s    = ST_SLP_ISO;
            wait_cnt_next_s = WaitZero;
          end else begin
            state_next_s = ST_ON;
          end
        end
        ST_SLP_ISO: begin
          if (iso_ack_clusters_i[g]) begin
            state_next_s = ST_SLP_CLK;
          end else if (wait_expired_s) begin
            state_next_s  = ST_SLP_CLK;
            set_timeout_s = 1'b1;
          end else begin
            wait_cnt_next_s = wait_inc_s;
          end
        end
        ST_SLP_CLK: begin
          state_next_s = ST_OFF;
        end
        default: begin
          state_next_s = ST_OFF;
        end
      endcase
      // Set has priority over a simultaneous clear.
      if (set_timeout_s) begin
        timeout_next_s = 1'b1;
      end else if (clear_timeout_i[g]) begin
        timeout_next_s = 1'b0;
      end else begin
        timeout_next_s = timeout_r;
      end
    end

    // State, counters, sticky flag and registered outputs for one cluster.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        state_r    <= ST_OFF;
        rst_cnt_r  <= 8'd0;
        wait_cnt_r <= WaitZero;
        timeout_r  <= 1'b0;
        out_r      <= OutOff;
      end else begin
        state_r    <= state_next_s;
        rst_cnt_r  <= rst_cnt_next_s;
        wait_cnt_r <= wait_cnt_next_s;
        timeout_r  <= timeout_next_s;
        // Outputs are registered from the next state so they align with state_r.
        out_r      <= decode_outputs(state_next_s);
      end
    end

    assign rst_clusters_no[g]   = out_r[4];
    assign iso_en_clusters_o[g] = out_r[3];
    assign clk_gate_en_o[g]     = out_r[2];
    assign on_o[g]              = out_r[1];
    assign busy_o[g]            = out_r[0];
    assign timeout_o[g]         = timeout_r;
  end

endmodule
